// File: rtl/pipelined_adder_pkg.sv
// pipelined_adder_pkg: shared constants and helpers for pipelined_adder.
// Provides the default operand width and the result-width helper.
package pipelined_adder_pkg;

    localparam int WIDTH_DEF = 16;

    // Result carries one extra bit for the carry-out.
    function automatic int sum_width(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/pipelined_adder_slice.sv
// adder_slice: N-bit combinational ripple adder with carry in/out.
// Ports: a, b (N) operands; cin carry-in; s (N) sum; cout carry-out.
module adder_slice #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic c;

    always_comb begin
        s = '0;
        c = cin;
        for (int i = 0; i < N; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: two-stage unsigned adder, low half then high half.
// Ports: clk; rst async active-high; n1, n2 (WIDTH) operands;
//        sum (WIDTH+1) registered n1+n2, MSB is carry-out, latency 2.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [WIDTH-1:0]            n1,
    input  logic [WIDTH-1:0]            n2,
    output logic [sum_width(WIDTH)-1:0] sum
);

    localparam int LO_WIDTH = WIDTH / 2;
    localparam int HI_WIDTH = WIDTH - LO_WIDTH;

    logic [LO_WIDTH-1:0] lo_sum_d;
    logic                lo_carry_d;
    logic [LO_WIDTH-1:0] lo_sum_q;
    logic                lo_carry_q;
    logic [HI_WIDTH-1:0] n1_hi_q;
    logic [HI_WIDTH-1:0] n2_hi_q;
    logic [HI_WIDTH-1:0] hi_sum;
    logic                hi_carry;

    adder_slice #(.N(LO_WIDTH)) u_lo (
        .a    (n1[LO_WIDTH-1:0]),
        .b    (n2[LO_WIDTH-1:0]),
        .cin  (1'b0),
        .s    (lo_sum_d),
        .cout (lo_carry_d)
    );

    // Stage 1: low-half result and the raw high halves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_sum_q   <= '0;
            lo_carry_q <= 1'b0;
            n1_hi_q    <= '0;
            n2_hi_q    <= '0;
        end else begin
            lo_sum_q   <= lo_sum_d;
            lo_carry_q <= lo_carry_d;
            n1_hi_q    <= n1[WIDTH-1:LO_WIDTH];
            n2_hi_q    <= n2[WIDTH-1:LO_WIDTH];
        end
    end

    // The inter-half carry is taken only from its register,
    // so each stage holds a half-width carry chain.
    adder_slice #(.N(HI_WIDTH)) u_hi (
        .a    (n1_hi_q),
        .b    (n2_hi_q),
        .cin  (lo_carry_q),
        .s    (hi_sum),
        .cout (hi_carry)
    );

    // Stage 2: assemble the full result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else begin
            sum <= {hi_carry, hi_sum, lo_sum_q};
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and random checks of pipelined_adder.
// Directed vectors carry hand-computed sums; random uses a delay model.
module tb_pipelined_adder;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [16:0] sum;

    int errs;
    int checks;

    logic [16:0] m1;
    logic [16:0] m2;

    logic [15:0] va [10];
    logic [15:0] vb [10];
    logic [16:0] ve [10];

    pipelined_adder #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .n1  (a),
        .n2  (b),
        .sum (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Golden model: full-width sum delayed two edges.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m1 <= '0;
            m2 <= '0;
        end else begin
            m1 <= {1'b0, a} + {1'b0, b};
            m2 <= m1;
        end
    end

    task automatic chk(input string tag,
                       input logic [16:0] got,
                       input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%05h expected 0x%05h",
                     tag, got, exp);
        end
    endtask

    task automatic cyc(input logic [15:0] x,
                       input logic [15:0] y,
                       input logic r);
        @(negedge clk);
        rst = r;
        a   = x;
        b   = y;
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input string tag,
                        input logic [15:0] x,
                        input logic [15:0] y,
                        input logic [16:0] exp);
        cyc(x, y, 1'b0);
        cyc(16'h0, 16'h0, 1'b0);
        chk(tag, sum, exp);
    endtask

    initial begin
        int r0, r1, r2;
        errs   = 0;
        checks = 0;
        rst    = 1'b1;
        a      = '0;
        b      = '0;
        va = '{16'd8, 16'd11, 16'd10, 16'd13, 16'd27,
               16'd39, 16'd57, 16'd77, 16'd83, 16'd91};
        vb = '{16'd9, 16'd13, 16'd17, 16'd24, 16'd35,
               16'd47, 16'd75, 16'd81, 16'd89, 16'd93};
        ve = '{17'd17, 17'd24, 17'd27, 17'd37, 17'd62,
               17'd86, 17'd132, 17'd158, 17'd172, 17'd184};

        #3;
        chk("por", sum, 17'h0);
        cyc(16'h0, 16'h0, 1'b1);
        cyc(16'h0, 16'h0, 1'b0);
        chk("rel0", sum, 17'h0);

        // Async clear from a nonzero pipeline, mid-cycle.
        cyc(16'hFFFF, 16'hFFFF, 1'b0);
        cyc(16'hFFFF, 16'hFFFF, 1'b0);
        chk("pre_rst", sum, 17'h1FFFE);
        #2;
        rst = 1'b1;
        #1;
        chk("async_clr", sum, 17'h0);
        for (int i = 0; i < 3; i++) begin
            cyc(16'hFFFF, 16'hFFFF, 1'b1);
            chk("rst_hold", sum, 17'h0);
        end

        // Back-to-back stream; result j shows after edge j+1.
        for (int j = 0; j <= 10; j++) begin
            if (j < 10) cyc(va[j], vb[j], 1'b0);
            else        cyc(16'h0, 16'h0, 1'b0);
            if (j == 0) chk("stream_first", sum, 17'h0);
            else        chk($sformatf("stream%0d", j - 1),
                            sum, ve[j - 1]);
        end

        pair("carry_lo", 16'h00FF, 16'h0001, 17'h00100);
        pair("carry_mid", 16'h7FFF, 16'h0001, 17'h08000);
        pair("max", 16'hFFFF, 16'hFFFF, 17'h1FFFE);
        pair("cout", 16'hFFFF, 16'h0001, 17'h10000);
        pair("zero", 16'h0000, 16'h0000, 17'h00000);

        // Reset pulse across the edge that would emit 300.
        cyc(16'd100, 16'd200, 1'b0);
        @(negedge clk);
        a = 16'd300;
        b = 16'd400;
        #4;
        rst = 1'b1;
        #1;
        chk("mid_during", sum, 17'h0);
        #1;
        chk("mid_edge", sum, 17'h0);
        cyc(16'd5, 16'd6, 1'b0);
        chk("mid_after", sum, 17'h0);
        cyc(16'd0, 16'd0, 1'b0);
        chk("mid_first", sum, 17'd11);
        cyc(16'd0, 16'd0, 1'b0);
        chk("mid_next", sum, 17'h0);

        // Random stream with three reset cycles.
        r0 = $urandom_range(10, 300);
        r1 = $urandom_range(350, 650);
        r2 = $urandom_range(700, 990);
        for (int i = 0; i < 1000; i++) begin
            logic rr;
            rr = (i == r0) || (i == r1) || (i == r2);
            cyc(16'($urandom), 16'($urandom), rr);
            chk("rand", sum, m2);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
